matrix_operand_feeder: RTL and testbench
========================================

Name: matrix_operand_feeder

Overview:
Upstream stage of the half matrix multiplier. It buffers one A matrix and one B matrix, written row by row over a bus-width write port. On a go command it streams the rows into the multiplier using the multiplier's row-slot protocol: one row per cycle, start_bit on row 0. It then waits for the multiplier's done, with a timeout guard.

Parameters:
BUS_WIDTH, 32, width of one matrix row in bits
DATA_WIDTH, 8, width of one element
DIM, BUS_WIDTH/DATA_WIDTH, matrix dimension (rows = columns); supported values 2..4
TIMEOUT, 64, maximum cycles spent in WAIT for done_i before err_o is raised
ROW_W, (DIM>1 ? $clog2(DIM) : 1), row index width (derived)

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  asynchronous, active-high reset
wr_en_i  in  1  row write strobe
wr_sel_i  in  1  0 = write an A row, 1 = write a B row
wr_row_i  in  ROW_W  row index of the write
wr_data_i  in  BUS_WIDTH  row data; element 0 is in the MSBs
go_i  in  1  start a feed
busy_i  in  1  multiplier busy (status only, visible in the bench)
done_i  in  1  multiplier done pulse
ready_o  out  1  1 in IDLE only
a_row_o  out  DIM*BUS_WIDTH  to multiplier a_row_i
b_col_o  out  DIM*BUS_WIDTH  to multiplier b_col_i
start_bit_o  out  1  to multiplier start_bit
done_o  out  1  one-cycle pulse when the multiplier finishes
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (asynchronous, rst_ni=1):
  - State goes to IDLE.
  - Both row buffers clear to 0.
  - a_row_o, b_col_o, start_bit_o, done_o and err_o go to 0; ready_o goes to 1.
  - Reset applies immediately, including mid-FEED or mid-WAIT; no partial stream resumes afterwards.
- States: IDLE, FEED, WAIT, FIN.
- IDLE:
  - wr_en_i writes wr_data_i into buffer wr_sel_i at row wr_row_i on the clock edge.
  - wr_row_i >= DIM: the write is dropped.
  - go_i=1 with wr_en_i=0: move to FEED, row counter k=0, err_o cleared.
  - go_i=1 with wr_en_i=1 in the same cycle: the write wins and go_i is ignored (ready_o stays 1).
- FEED:
  - All outputs are registered. The go edge loads row 0 onto the outputs, so row 0 is visible for the cycle after go_i is sampled.
  - Output cycle k (k = 0..DIM-1):
    - Slot k of a_row_o carries A row k; all other slots are 0. Slot k occupies bits [(DIM-k)*BUS_WIDTH-1 -: BUS_WIDTH], so slot 0 is in the MSBs.
    - b_col_o uses the same layout with B row k.
    - start_bit_o=1 only when k=0.
  - After row DIM-1 the outputs go to all-zero and the state moves to WAIT, with the timeout counter cleared.
- WAIT:
  - The outputs hold zero.
  - The timeout counter increments every cycle.
  - done_i=1: go to FIN.
  - Otherwise, when the counter reaches TIMEOUT-1: set err_o=1 and go to IDLE. err_o holds until the next accepted go.
  - If done_i arrives on the same cycle the counter hits TIMEOUT-1, done wins and err_o stays 0.
- FIN: done_o=1 for exactly one cycle, then IDLE.
- Outside IDLE:
  - wr_en_i and go_i are ignored; buffers are frozen during a feed.
  - done_i is ignored outside WAIT.
- busy_i does not affect control.
- Latency:
  - From go sampled to row 0 visible: 1 cycle.
  - A feed occupies DIM cycles.
  - done_o asserts 1 cycle after done_i is sampled in WAIT.
- No arithmetic on data; elements pass through bit-exact.

Decomposition:
- Shared package matmul_pkg holds:
  - the DIM derivation and ROW_W function
  - the feeder state enum (IDLE, FEED, WAIT, FIN)
  - a slot-placement helper that positions one row into the DIM*BUS_WIDTH vector.
- One sub-module, matrix_row_bank: a DIM x BUS_WIDTH register file with a write port and a combinational read by index. It is instantiated twice, once for A and once for B.
- The FSM and counters live in the top module.

Test Plan:
1. Basic feed (DIM=4):
   - Stimulus: load A = B = rows 01020304, 05060708, 090A0B0C, 0D0E0F10; pulse go.
   - Response:
     - Next cycle: a_row_o = 128'h01020304_00000000_00000000_00000000 with start_bit_o=1.
     - Following cycle: 128'h00000000_05060708_00000000_00000000 with start_bit_o=0.
     - Then the remaining two rows in slots 2 and 3, then zeros.
     - done_i pulse: done_o high for 1 cycle, then ready_o=1.
2. DIM=2 (BUS_WIDTH=16):
   - Stimulus: rows 0102, 0506; go.
   - Response: 32'h0102_0000 with start_bit_o=1, then 32'h0000_0506, then 0.
3. Timeout:
   - Stimulus: feed with done_i never asserted.
   - Response: err_o=1 exactly TIMEOUT cycles after entering WAIT; ready_o=1. The next go clears err_o.
4. Reset mid-FEED:
   - Stimulus: assert rst_ni during row 1, asynchronously to the clock.
   - Response: outputs go to 0 immediately and ready_o=1. A subsequent go with no writes streams all-zero rows.
5. Collisions:
   - Stimulus: go during WAIT; wr_en_i during FEED; wr_en_i together with go in IDLE.
   - Response: all ignored (the IDLE write is accepted, its go dropped). Buffer contents and stream are unchanged.
6. done_i and timeout on the same cycle:
   - Stimulus: done_i asserted on the TIMEOUT-1 cycle.
   - Response: done_o pulses; err_o stays 0.

Source files
------------

// File: rtl/matrix_operand_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  matmul_pkg
//  Shared dimension helpers, feeder state encoding and row slot placement.
//  Revision: 1.0
// ============================================================================
package matmul_pkg;

    localparam int c_max_bus_width = 64;
    localparam int c_max_dim       = 4;
    localparam int c_max_vec_width = c_max_bus_width * c_max_dim;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_FEED = 2'd1,
        FS_WAIT = 2'd2,
        FS_FIN  = 2'd3
    } feeder_state_e;

    function automatic int calc_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    function automatic int calc_row_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    // Slot 0 lands in the MSBs of a dim*bus_width vector; callers truncate.
    function automatic logic [c_max_vec_width-1:0] place_slot(
        input logic [c_max_bus_width-1:0] row,
        input int                         slot,
        input int                         dim,
        input int                         bus_width
    );
        logic [c_max_vec_width-1:0] v;
        v = '0;
        v[c_max_bus_width-1:0] = row;
        return v << ((dim - 1 - slot) * bus_width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_operand_feeder_if.sv
`default_nettype none
// ============================================================================
//  matrix_operand_feeder_if
//  Write port, control and multiplier-side signals of the operand feeder.
//  Revision: 1.0
// ============================================================================
interface matrix_operand_feeder_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8
);
    import matmul_pkg::*;

    localparam int DIM   = calc_dim(BUS_WIDTH, DATA_WIDTH);
    localparam int ROW_W = calc_row_w(DIM);

    logic                     wr_en_i;
    logic                     wr_sel_i;
    logic [ROW_W-1:0]         wr_row_i;
    logic [BUS_WIDTH-1:0]     wr_data_i;
    logic                     go_i;
    logic                     busy_i;
    logic                     done_i;
    logic                     ready_o;
    logic [DIM*BUS_WIDTH-1:0] a_row_o;
    logic [DIM*BUS_WIDTH-1:0] b_col_o;
    logic                     start_bit_o;
    logic                     done_o;
    logic                     err_o;

    modport master (
        output wr_en_i, wr_sel_i, wr_row_i, wr_data_i, go_i, busy_i, done_i,
        input  ready_o, a_row_o, b_col_o, start_bit_o, done_o, err_o
    );

    modport slave (
        input  wr_en_i, wr_sel_i, wr_row_i, wr_data_i, go_i, busy_i, done_i,
        output ready_o, a_row_o, b_col_o, start_bit_o, done_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/matrix_operand_feeder_row_bank.sv
`default_nettype none
// ============================================================================
//  matrix_row_bank
//  DIM x BUS_WIDTH register file, one write port, combinational indexed read.
//  Revision: 1.0
// ============================================================================
module matrix_row_bank #(
    parameter int DIM       = 4,
    parameter int BUS_WIDTH = 32,
    parameter int ROW_W     = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 wr_en,
    input  wire logic [ROW_W-1:0]     wr_row,
    input  wire logic [BUS_WIDTH-1:0] wr_data,
    input  wire logic [ROW_W-1:0]     rd_row,
    output logic      [BUS_WIDTH-1:0] rd_data
);

    logic [BUS_WIDTH-1:0] r_mem [DIM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en && (int'(wr_row) < DIM)) begin
            r_mem[wr_row] <= wr_data;
        end
    end

    assign rd_data = (int'(rd_row) < DIM) ? r_mem[rd_row] : '0;

endmodule
`default_nettype wire

// File: rtl/matrix_operand_feeder.sv
`default_nettype none
// ============================================================================
//  matrix_operand_feeder
//  Buffers A/B matrices and streams them row-by-row into the multiplier.
//  Revision: 1.0
// ============================================================================
module matrix_operand_feeder
    import matmul_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    matrix_operand_feeder_if.slave  bus
);

    localparam int DIM   = calc_dim(BUS_WIDTH, DATA_WIDTH);
    localparam int ROW_W = calc_row_w(DIM);
    localparam int VEC_W = DIM * BUS_WIDTH;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0]       c_st_idle  = FS_IDLE;
    localparam logic [1:0]       c_st_feed  = FS_FEED;
    localparam logic [1:0]       c_st_wait  = FS_WAIT;
    localparam logic [1:0]       c_st_fin   = FS_FIN;
    localparam logic [TO_W-1:0]  c_to_last  = TO_W'(TIMEOUT - 1);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(DIM - 1);

    logic [1:0]           r_state;
    logic [ROW_W-1:0]     r_k;
    logic [TO_W-1:0]      r_tcnt;
    logic [VEC_W-1:0]     r_a_row;
    logic [VEC_W-1:0]     r_b_col;
    logic                 r_start;
    logic                 r_done;
    logic                 r_err;

    logic                 w_idle;
    logic                 w_wr_en;
    logic [ROW_W-1:0]     w_rd_row;
    logic [BUS_WIDTH-1:0] w_a_rd;
    logic [BUS_WIDTH-1:0] w_b_rd;
    logic [VEC_W-1:0]     w_a_slot;
    logic [VEC_W-1:0]     w_b_slot;
    logic                 w_unused_busy;

    assign w_idle        = (r_state == c_st_idle);
    assign w_wr_en       = w_idle & bus.wr_en_i;
    assign w_unused_busy = bus.busy_i;

    // Reads look one row ahead so the registered outputs show row k in cycle k.
    assign w_rd_row = (r_state == c_st_feed) ? ROW_W'(r_k + 1'b1) : '0;

    matrix_row_bank #(
        .DIM       (DIM),
        .BUS_WIDTH (BUS_WIDTH),
        .ROW_W     (ROW_W)
    ) u_bank_a (
        .clk     (clk_i),
        .rst     (rst_ni),
        .wr_en   (w_wr_en & ~bus.wr_sel_i),
        .wr_row  (bus.wr_row_i),
        .wr_data (bus.wr_data_i),
        .rd_row  (w_rd_row),
        .rd_data (w_a_rd)
    );

    matrix_row_bank #(
        .DIM       (DIM),
        .BUS_WIDTH (BUS_WIDTH),
        .ROW_W     (ROW_W)
    ) u_bank_b (
        .clk     (clk_i),
        .rst     (rst_ni),
        .wr_en   (w_wr_en & bus.wr_sel_i),
        .wr_row  (bus.wr_row_i),
        .wr_data (bus.wr_data_i),
        .rd_row  (w_rd_row),
        .rd_data (w_b_rd)
    );

    always_comb begin
        logic [c_max_bus_width-1:0] v_a_ext;
        logic [c_max_bus_width-1:0] v_b_ext;
        v_a_ext = '0;
        v_b_ext = '0;
        v_a_ext[BUS_WIDTH-1:0] = w_a_rd;
        v_b_ext[BUS_WIDTH-1:0] = w_b_rd;
        w_a_slot = VEC_W'(place_slot(v_a_ext, int'(w_rd_row), DIM, BUS_WIDTH));
        w_b_slot = VEC_W'(place_slot(v_b_ext, int'(w_rd_row), DIM, BUS_WIDTH));
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            r_state <= c_st_idle;
            r_k     <= '0;
            r_tcnt  <= '0;
            r_a_row <= '0;
            r_b_col <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // A write in the same cycle as go takes priority.
                    if (!bus.wr_en_i && bus.go_i) begin
                        r_state <= c_st_feed;
                        r_k     <= '0;
                        r_a_row <= w_a_slot;
                        r_b_col <= w_b_slot;
                        r_start <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                c_st_feed: begin
                    r_start <= 1'b0;
                    if (r_k == c_last_row) begin
                        r_a_row <= '0;
                        r_b_col <= '0;
                        r_tcnt  <= '0;
                        r_state <= c_st_wait;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_a_row <= w_a_slot;
                        r_b_col <= w_b_slot;
                    end
                end
                c_st_wait: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (bus.done_i) begin
                        r_done  <= 1'b1;
                        r_state <= c_st_fin;
                    end else if (r_tcnt == c_to_last) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                c_st_fin: begin
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.ready_o     = w_idle;
    assign bus.a_row_o     = r_a_row;
    assign bus.b_col_o     = r_b_col;
    assign bus.start_bit_o = r_start;
    assign bus.done_o      = r_done;
    assign bus.err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_feeder.sv
`default_nettype none
// ============================================================================
//  tb_matrix_operand_feeder
//  Directed self-checking bench for DIM=4 and DIM=2 feeder instances.
//  Revision: 1.0
// ============================================================================
module tb_matrix_operand_feeder;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    matrix_operand_feeder_if #(.BUS_WIDTH(32), .DATA_WIDTH(8)) bus4 ();
    matrix_operand_feeder_if #(.BUS_WIDTH(16), .DATA_WIDTH(8)) bus2 ();

    matrix_operand_feeder #(.BUS_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT(64)) u_dut4 (
        .clk_i  (clk),
        .rst_ni (rst),
        .bus    (bus4)
    );

    matrix_operand_feeder #(.BUS_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT(64)) u_dut2 (
        .clk_i  (clk),
        .rst_ni (rst),
        .bus    (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wr4(input logic sel, input logic [1:0] row, input logic [31:0] data);
        bus4.wr_en_i   = 1'b1;
        bus4.wr_sel_i  = sel;
        bus4.wr_row_i  = row;
        bus4.wr_data_i = data;
        tick();
        bus4.wr_en_i   = 1'b0;
    endtask

    task automatic wr2(input logic sel, input logic row, input logic [15:0] data);
        bus2.wr_en_i   = 1'b1;
        bus2.wr_sel_i  = sel;
        bus2.wr_row_i  = row;
        bus2.wr_data_i = data;
        tick();
        bus2.wr_en_i   = 1'b0;
    endtask

    task automatic go4();
        bus4.go_i = 1'b1;
        tick();
        bus4.go_i = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus4.wr_en_i = 1'b0; bus4.wr_sel_i = 1'b0; bus4.wr_row_i = '0; bus4.wr_data_i = '0;
        bus4.go_i = 1'b0; bus4.busy_i = 1'b0; bus4.done_i = 1'b0;
        bus2.wr_en_i = 1'b0; bus2.wr_sel_i = 1'b0; bus2.wr_row_i = '0; bus2.wr_data_i = '0;
        bus2.go_i = 1'b0; bus2.busy_i = 1'b0; bus2.done_i = 1'b0;

        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chkb("rst_ready", bus4.ready_o, 1'b1);
        chkv("rst_a", 128'(bus4.a_row_o), 128'h0);
        chkv("rst_b", 128'(bus4.b_col_o), 128'h0);
        chkb("rst_start", bus4.start_bit_o, 1'b0);
        chkb("rst_done", bus4.done_o, 1'b0);
        chkb("rst_err", bus4.err_o, 1'b0);
        chkb("rst_ready2", bus2.ready_o, 1'b1);

        // Basic DIM=4 feed, with a write during FEED and a go during WAIT
        wr4(1'b0, 2'd0, 32'h01020304); wr4(1'b1, 2'd0, 32'h01020304);
        wr4(1'b0, 2'd1, 32'h05060708); wr4(1'b1, 2'd1, 32'h05060708);
        wr4(1'b0, 2'd2, 32'h090A0B0C); wr4(1'b1, 2'd2, 32'h090A0B0C);
        wr4(1'b0, 2'd3, 32'h0D0E0F10); wr4(1'b1, 2'd3, 32'h0D0E0F10);
        go4();
        chkv("f_a0", bus4.a_row_o, 128'h01020304_00000000_00000000_00000000);
        chkv("f_b0", bus4.b_col_o, 128'h01020304_00000000_00000000_00000000);
        chkb("f_start0", bus4.start_bit_o, 1'b1);
        chkb("f_ready0", bus4.ready_o, 1'b0);
        wr4(1'b0, 2'd1, 32'hFFFFFFFF);
        chkv("f_a1", bus4.a_row_o, 128'h00000000_05060708_00000000_00000000);
        chkb("f_start1", bus4.start_bit_o, 1'b0);
        tick();
        chkv("f_a2", bus4.a_row_o, 128'h00000000_00000000_090A0B0C_00000000);
        tick();
        chkv("f_a3", bus4.a_row_o, 128'h00000000_00000000_00000000_0D0E0F10);
        chkv("f_b3", bus4.b_col_o, 128'h00000000_00000000_00000000_0D0E0F10);
        tick();
        chkv("f_azero", bus4.a_row_o, 128'h0);
        chkb("f_startz", bus4.start_bit_o, 1'b0);
        go4();
        chkb("wait_go_ign", bus4.ready_o, 1'b0);
        chkv("wait_a", bus4.a_row_o, 128'h0);
        bus4.done_i = 1'b1;
        tick();
        bus4.done_i = 1'b0;
        chkb("fin_done", bus4.done_o, 1'b1);
        chkb("fin_ready", bus4.ready_o, 1'b0);
        tick();
        chkb("fin_done_end", bus4.done_o, 1'b0);
        chkb("fin_ready_end", bus4.ready_o, 1'b1);

        // Write together with go in IDLE: write accepted, go dropped
        bus4.go_i = 1'b1;
        wr4(1'b0, 2'd2, 32'hAABBCCDD);
        bus4.go_i = 1'b0;
        chkb("wrgo_ready", bus4.ready_o, 1'b1);
        chkb("wrgo_start", bus4.start_bit_o, 1'b0);

        // Timeout feed; also confirms buffer contents after the collisions
        go4();
        tick();
        chkv("t_a1", bus4.a_row_o, 128'h00000000_05060708_00000000_00000000);
        tick();
        chkv("t_a2", bus4.a_row_o, 128'h00000000_00000000_AABBCCDD_00000000);
        chkv("t_b2", bus4.b_col_o, 128'h00000000_00000000_090A0B0C_00000000);
        tick();
        tick();
        repeat (63) tick();
        chkb("t_err_pre", bus4.err_o, 1'b0);
        chkb("t_ready_pre", bus4.ready_o, 1'b0);
        tick();
        chkb("t_err", bus4.err_o, 1'b1);
        chkb("t_ready", bus4.ready_o, 1'b1);
        tick();
        chkb("t_err_sticky", bus4.err_o, 1'b1);
        go4();
        chkb("t_err_clr", bus4.err_o, 1'b0);
        repeat (4) tick();
        bus4.done_i = 1'b1;
        tick();
        bus4.done_i = 1'b0;
        chkb("t_done", bus4.done_o, 1'b1);
        tick();

        // done_i on the last timeout cycle: done wins
        go4();
        repeat (4) tick();
        repeat (63) tick();
        bus4.done_i = 1'b1;
        tick();
        bus4.done_i = 1'b0;
        chkb("c_done", bus4.done_o, 1'b1);
        chkb("c_err", bus4.err_o, 1'b0);
        tick();
        chkb("c_ready", bus4.ready_o, 1'b1);
        chkb("c_err_after", bus4.err_o, 1'b0);

        // Asynchronous reset in the middle of row 1
        go4();
        tick();
        chkv("r_a1", bus4.a_row_o, 128'h00000000_05060708_00000000_00000000);
        #2 rst = 1'b1;
        #1;
        chkv("r_a_async", bus4.a_row_o, 128'h0);
        chkv("r_b_async", bus4.b_col_o, 128'h0);
        chkb("r_ready_async", bus4.ready_o, 1'b1);
        #1 rst = 1'b0;
        go4();
        chkv("r_a_zero", bus4.a_row_o, 128'h0);
        chkv("r_b_zero", bus4.b_col_o, 128'h0);
        chkb("r_start", bus4.start_bit_o, 1'b1);
        tick();
        chkv("r_a1_zero", bus4.a_row_o, 128'h0);
        repeat (3) tick();
        bus4.done_i = 1'b1;
        tick();
        bus4.done_i = 1'b0;
        tick();

        // DIM=2 instance
        wr2(1'b0, 1'b0, 16'h0102); wr2(1'b1, 1'b0, 16'h0102);
        wr2(1'b0, 1'b1, 16'h0506); wr2(1'b1, 1'b1, 16'h0506);
        bus2.go_i = 1'b1;
        tick();
        bus2.go_i = 1'b0;
        chkv("d2_a0", 128'(bus2.a_row_o), 128'h0102_0000);
        chkv("d2_b0", 128'(bus2.b_col_o), 128'h0102_0000);
        chkb("d2_start0", bus2.start_bit_o, 1'b1);
        tick();
        chkv("d2_a1", 128'(bus2.a_row_o), 128'h0000_0506);
        chkb("d2_start1", bus2.start_bit_o, 1'b0);
        tick();
        chkv("d2_azero", 128'(bus2.a_row_o), 128'h0);
        bus2.done_i = 1'b1;
        tick();
        bus2.done_i = 1'b0;
        chkb("d2_done", bus2.done_o, 1'b1);
        tick();
        chkb("d2_ready", bus2.ready_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
